w_ptr_status: RTL
=================

Name: w_ptr_status

Overview:
- Write-domain status stage of the asynchronous FIFO. It sits directly downstream of the write binary address counter and consumes its binary pointer plus the write enable.
- Produces the gray-coded write pointer for the read domain and synchronizes the read gray pointer into w_clk.
- Generates registered full, almost-full, fill level and a sticky overflow flag.
- The write counter uses w_full from this block to gate its increments.

Parameters:
- ADDR_WIDTH, 3: FIFO depth is 2^ADDR_WIDTH; all pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: flops in the read-pointer synchronizer chain. Legal range is 2 or more.
- AF_THRESH, 6: almost-full asserts when fill level >= AF_THRESH. Legal range is 1..2^ADDR_WIDTH.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  synchronous, active-high reset.
- w_en  input  1  write request (same signal the counter sees).
- w_addr  input  ADDR_WIDTH+1  binary write pointer from the write counter.
- r_gptr_async  input  ADDR_WIDTH+1  gray read pointer, launched from the read clock domain.
- w_ovf_clr  input  1  clears the sticky overflow flag.
- w_gptr  output  ADDR_WIDTH+1  registered gray write pointer, sent to the read domain.
- w_full  output  1  registered full flag.
- w_almost_full  output  1  registered almost-full flag.
- w_level  output  ADDR_WIDTH+1  registered fill level, range 0..2^ADDR_WIDTH.
- w_ovf  output  1  sticky overflow: a write was attempted while full.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports are named w_clk and w_rst.
- Reset: at any w_clk edge with w_rst=1, all registers load 0.
  - Affected: synchronizer chain, w_gptr, w_full, w_almost_full, w_level, w_ovf.
  - Reset overrides all inputs, including w_en and w_ovf_clr.
  - The write counter must be reset in the same cycle. Reset mid-operation (including while full) returns the block to empty: w_full=0, w_level=0 on the cycle after the reset edge.
- Internal combinational signals:
  - inc = w_en & ~w_full.
  - w_addr_nxt = w_addr + inc, modulo 2^(ADDR_WIDTH+1). This matches the value the counter loads at the same edge.
  - w_gnxt = w_addr_nxt ^ (w_addr_nxt >> 1).
- Gray pointer: w_gptr <= w_gnxt each edge. w_gptr therefore always equals gray(w_addr) and has zero cycles of lag versus the counter.
- Synchronizer: r_gptr_async passes through SYNC_STAGES flops; rq denotes the final stage. No logic is allowed between the flops.
- Read pointer in binary: rbin is the gray-to-binary conversion of rq (XOR prefix from the MSB down). It is combinational.
- Full:
  - Condition: w_full <= (w_gnxt == {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]}).
  - Equivalently, w_addr_nxt - rbin == 2^ADDR_WIDTH.
  - Full asserts at the same edge that performs the last write.
- Level: w_level <= (w_addr_nxt - rbin) mod 2^(ADDR_WIDTH+1). It never exceeds 2^ADDR_WIDTH with a legal read side.
- Almost-full: w_almost_full <= ((w_addr_nxt - rbin) >= AF_THRESH). The comparison is unsigned at ADDR_WIDTH+1 bits.
- Latency of read-side updates: a change on r_gptr_async reaches w_full, w_level and w_almost_full after exactly SYNC_STAGES+1 w_clk edges. Full deassertion is therefore pessimistic (late), never early.
- Overflow:
  - Set condition: an edge where w_en=1 and w_full=1.
  - Set sets w_ovf=1 and holds it; the pointer does not advance.
  - w_ovf_clr=1 clears it.
  - Set and clear in the same cycle leaves w_ovf=1 (set wins).
- Wrap-around: the pointer wraps from 2^(ADDR_WIDTH+1)-1 to 0 with no special handling. Gray encoding and the level arithmetic are modular.
- Simultaneous write and read-pointer change: both are applied to the same-edge computation. The synchronized read value used is whatever rq holds before the edge.

Test Plan:
- Reset priority (ADDR_WIDTH=3): hold w_rst=1 for 2 edges with w_en=1 and r_gptr_async=4'b1111 -> every output is 0. Release -> w_full=0, w_level=0.
- Fill (r_gptr_async=0, counter model driving w_addr, w_en=1 for 8 edges):
  - w_almost_full rises at the 6th write edge.
  - w_full rises at the 8th write edge, with w_level=8 and w_gptr=4'b1100.
  - A 9th w_en leaves w_addr=8.
- Overflow: from full, w_en=1 for 1 edge -> w_ovf=1 next cycle. w_ovf_clr=1 together with another w_en=1 -> w_ovf stays 1. w_ovf_clr=1 with w_en=0 -> w_ovf=0.
- Drain latency: from full, set r_gptr_async=4'b0010 (bin 3) -> w_full deasserts exactly 3 edges later, w_level=5 and w_almost_full=0 on that same edge.
- Wrap full: preload w_addr=1 (after wrap) and r_gptr_async=4'b1101 (bin 9), wait 3 edges -> w_full=1 and w_level=8. Write attempts do not advance w_addr.
- Reset mid-operation: with w_full=1 and w_ovf=1, assert w_rst for 1 edge (counter reset too) -> next cycle all outputs are 0. A subsequent write gives w_gptr=4'b0001 and w_level=1 on that edge.

Source files
------------

// File: rtl/w_ptr_status.sv
`default_nettype none
// ============================================================================
// Module      : w_ptr_status
// Description : Write-domain status stage of an asynchronous FIFO. Gray-codes
//               the next write pointer for the read domain, synchronizes the
//               read gray pointer into w_clk, and produces registered full,
//               almost-full, fill level and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module w_ptr_status #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   w_addr,
  input  logic [ADDR_WIDTH:0]   r_gptr_async,
  input  logic                  w_ovf_clr,
  output logic [ADDR_WIDTH:0]   w_gptr,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_ovf
);

  localparam logic [ADDR_WIDTH:0] c_af_thresh = (ADDR_WIDTH+1)'(AF_THRESH);

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [ADDR_WIDTH:0] f_gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] r_sync [SYNC_STAGES];
  logic [ADDR_WIDTH:0] r_gptr;
  logic                r_full;
  logic                r_almost_full;
  logic [ADDR_WIDTH:0] r_level;
  logic                r_ovf;

  logic                w_inc;
  logic [ADDR_WIDTH:0] w_addr_nxt;
  logic [ADDR_WIDTH:0] w_gnxt;
  logic [ADDR_WIDTH:0] w_rq;
  logic [ADDR_WIDTH:0] w_rbin;
  logic [ADDR_WIDTH:0] w_diff;
  logic                w_full_nxt;

  // The counter advances at this same edge only when not already full, so
  // the pointer computed here is exactly what the counter will hold next.
  assign w_inc      = w_en & ~r_full;
  assign w_addr_nxt = w_addr + {{ADDR_WIDTH{1'b0}}, w_inc};
  assign w_gnxt     = w_addr_nxt ^ (w_addr_nxt >> 1);

  assign w_rq       = r_sync[SYNC_STAGES-1];
  assign w_rbin     = f_gray2bin(w_rq);
  assign w_diff     = w_addr_nxt - w_rbin;

  // Full when the write pointer is one lap ahead: top two gray bits inverted.
  assign w_full_nxt = (w_gnxt == {~w_rq[ADDR_WIDTH:ADDR_WIDTH-1], w_rq[ADDR_WIDTH-2:0]});

  // Plain flop chain bringing the read gray pointer into the write domain.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= r_gptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Registered gray pointer and status flags derived from the next pointer.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_gptr        <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
    end else begin
      r_gptr        <= w_gnxt;
      r_full        <= w_full_nxt;
      r_almost_full <= (w_diff >= c_af_thresh);
      r_level       <= w_diff;
    end
  end

  // Sticky overflow; a new overflow outranks a clear in the same cycle.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ovf <= 1'b0;
    end else if (w_en & r_full) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_gptr        = r_gptr;
  assign w_full        = r_full;
  assign w_almost_full = r_almost_full;
  assign w_level       = r_level;
  assign w_ovf         = r_ovf;

endmodule
`default_nettype wire
